// File: rtl/spi_pkg.sv
// Shared SPI definitions: slave FSM state encoding, mode bit positions and default word length.
package spi_pkg;

  localparam int unsigned SPI_WORD_LEN = 8;

  localparam int unsigned CPOL_BIT = 1;
  localparam int unsigned CPHA_BIT = 0;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// 2-FF synchronizer for an asynchronous pin, followed by registered rise/fall pulses.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;
  logic rise_q;
  logic fall_q;

  // Flops reset low so a pin already high after reset is only seen once it has synchronized.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      rise_q <= s2_q & ~prev_q;
      fall_q <= ~s2_q & prev_q;
    end
  end

  assign sync_o = s2_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave with oversampled pins, all four modes, MSB/LSB first, tx holding and rx buffers.
// Optional sticky receive-overrun flag when SPI_SLAVE_OVERRUN_EN is defined.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned WORD_LEN = SPI_WORD_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_LEN-1:0] data_in,
  input  logic                wr,
  output logic                buffempty,
  output logic                senderr,
  input  logic                res_senderr,
  output logic [WORD_LEN-1:0] data_out,
  input  logic                rd,
  output logic                charreceived,
  input  logic                lsbfirst,
  input  logic [1:0]          mode,
  input  logic                sck,
  input  logic                ss,
  input  logic                mosi,
  output logic                miso,
  output logic                miso_oe
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic                overrun
`endif
);

  localparam int unsigned CNT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

  logic sck_sync_unused;
  logic sck_rise;
  logic sck_fall;
  logic ss_sync;
  logic ss_rise;
  logic ss_fall;
  logic mosi_s1_q;
  logic mosi_s2_q;

  spi_state_e           state_q,     state_d;
  logic [1:0]           mode_q,      mode_d;
  logic                 lsb_q,       lsb_d;
  logic [WORD_LEN-1:0]  tx_q,        tx_d;
  logic [WORD_LEN-1:0]  rx_q,        rx_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [WORD_LEN-1:0]  hold_q,      hold_d;
  logic                 buffempty_q, buffempty_d;
  logic                 senderr_q,   senderr_d;
  logic [WORD_LEN-1:0]  dout_q,      dout_d;
  logic                 cr_q,        cr_d;
  logic                 miso_q,      miso_d;
  logic                 oe_q,        oe_d;
  logic                 present_q,   present_d;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic                 ovr_q,       ovr_d;
`endif

  logic                load;
  logic                take;
  logic                complete;
  logic                shift_act;
  logic                lead;
  logic                trail;
  logic                out_bit;
  logic [WORD_LEN-1:0] rx_new;
  logic [WORD_LEN-1:0] tx_shift;

  spi_sync_edge u_sck_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sck),
    .sync_o (sck_sync_unused),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge u_ss_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (ss),
    .sync_o (ss_sync),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      state_q     <= ST_SYNC;
      mode_q      <= 2'b00;
      lsb_q       <= 1'b0;
      tx_q        <= '1;
      rx_q        <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      buffempty_q <= 1'b1;
      senderr_q   <= 1'b0;
      dout_q      <= '0;
      cr_q        <= 1'b0;
      miso_q      <= 1'b1;
      oe_q        <= 1'b0;
      present_q   <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      ovr_q       <= 1'b0;
`endif
    end else begin
      mosi_s1_q   <= mosi;
      mosi_s2_q   <= mosi_s1_q;
      state_q     <= state_d;
      mode_q      <= mode_d;
      lsb_q       <= lsb_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      buffempty_q <= buffempty_d;
      senderr_q   <= senderr_d;
      dout_q      <= dout_d;
      cr_q        <= cr_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      present_q   <= present_d;
`ifdef SPI_SLAVE_OVERRUN_EN
      ovr_q       <= ovr_d;
`endif
    end
  end

  // Next-state, shift and host-handshake logic.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    lsb_d       = lsb_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    buffempty_d = buffempty_q;
    senderr_d   = senderr_q;
    dout_d      = dout_q;
    cr_d        = cr_q;
    miso_d      = miso_q;
    present_d   = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
    ovr_d       = ovr_q;
`endif
    load      = 1'b0;
    complete  = 1'b0;
    shift_act = 1'b0;

    lead     = mode_q[CPOL_BIT] ? sck_fall : sck_rise;
    trail    = mode_q[CPOL_BIT] ? sck_rise : sck_fall;
    out_bit  = lsb_q ? tx_q[0] : tx_q[WORD_LEN-1];
    tx_shift = lsb_q ? {1'b1, tx_q[WORD_LEN-1:1]} : {tx_q[WORD_LEN-2:0], 1'b1};
    rx_new   = lsb_q ? {mosi_s2_q, rx_q[WORD_LEN-1:1]} : {rx_q[WORD_LEN-2:0], mosi_s2_q};

    case (state_q)
      ST_SYNC: begin
        if (ss_sync) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (ss_fall) begin
          state_d   = ST_ACTIVE;
          mode_d    = mode;
          lsb_d     = lsbfirst;
          cnt_d     = '0;
          load      = 1'b1;
          present_d = ~mode[CPHA_BIT];
        end
      end
      ST_ACTIVE: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
        end else begin
          if (mode_q[CPHA_BIT] ? trail : lead) begin
            rx_d = rx_new;
            if (cnt_q == CNT_W'(WORD_LEN - 1)) begin
              complete = 1'b1;
              load     = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          shift_act = present_q | (mode_q[CPHA_BIT] ? lead : trail);
        end
      end
      default: state_d = ST_SYNC;
    endcase

    // tx_q always holds the bits not yet driven; a shift presents the next one.
    take = load & ~buffempty_q;
    if (load) begin
      tx_d = take ? hold_q : '1;
      if (take) buffempty_d = 1'b1;
    end else if (shift_act) begin
      tx_d = tx_shift;
    end

    if (ss_sync || (state_q != ST_ACTIVE)) begin
      miso_d = 1'b1;
    end else if (shift_act) begin
      miso_d = out_bit;
    end

    if (res_senderr) senderr_d = 1'b0;
    if (wr) begin
      if (buffempty_q || take) begin
        hold_d      = data_in;
        buffempty_d = 1'b0;
      end else begin
        senderr_d = 1'b1;
      end
    end

    if (rd) cr_d = 1'b0;
    if (complete) begin
      cr_d   = 1'b1;
      dout_d = rx_new;
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    if (res_senderr) ovr_d = 1'b0;
    if (complete && cr_q) ovr_d = 1'b1;
`endif
  end

  assign oe_d = (state_d == ST_ACTIVE) && !ss_sync;

  assign buffempty    = buffempty_q;
  assign senderr      = senderr_q;
  assign data_out     = dout_q;
  assign charreceived = cr_q;
  assign miso         = miso_q;
  assign miso_oe      = oe_q;
`ifdef SPI_SLAVE_OVERRUN_EN
  assign overrun      = ovr_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: bit-banged SPI master plus a word-level reference model.
module tb_spi_slave;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       wr;
  logic       buffempty;
  logic       senderr;
  logic       res_senderr;
  logic [7:0] data_out;
  logic       rd;
  logic       charreceived;
  logic       lsbfirst;
  logic [1:0] mode;
  logic       sck;
  logic       ss;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       overrun;
`endif

  spi_slave #(.WORD_LEN(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .wr           (wr),
    .buffempty    (buffempty),
    .senderr      (senderr),
    .res_senderr  (res_senderr),
    .data_out     (data_out),
    .rd           (rd),
    .charreceived (charreceived),
    .lsbfirst     (lsbfirst),
    .mode         (mode),
    .sck          (sck),
    .ss           (ss),
    .mosi         (mosi),
    .miso         (miso),
    .miso_oe      (miso_oe)
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    .overrun      (overrun)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Word-level model: holding buffer, receive buffer and sticky flags.
  logic       m_full, m_senderr, m_cr, m_ovr;
  logic [7:0] m_hold, m_dout;

  logic       pend_wr = 1'b0;
  logic [7:0] pend_data = 8'h00;

  typedef struct {
    logic [1:0] md;
    logic       lsb;
    logic       do_wr;
    logic [7:0] wdata;
    logic [7:0] mosi_w;
    logic [7:0] exp_miso;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0; m_senderr = 1'b0; m_cr = 1'b0; m_ovr = 1'b0;
    m_hold = 8'h00; m_dout = 8'h00;
  endtask

  function automatic logic [7:0] take();
    logic [7:0] v;
    v = m_full ? m_hold : 8'hFF;
    m_full = 1'b0;
    return v;
  endfunction

  task automatic model_wr(input logic [7:0] d);
    if (!m_full) begin
      m_hold = d;
      m_full = 1'b1;
    end else begin
      m_senderr = 1'b1;
    end
  endtask

  // Wait n clk cycles, issuing a pending single-cycle write in the first one.
  task automatic cyc(input int n);
    for (int c = 0; c < n; c++) begin
      if (pend_wr) begin
        wr = 1'b1; data_in = pend_data; pend_wr = 1'b0;
      end else begin
        wr = 1'b0;
      end
      @(negedge clk);
    end
    wr = 1'b0;
  endtask

  task automatic wr_pulse(input logic [7:0] d);
    model_wr(d);
    wr = 1'b1; data_in = d;
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_pulse();
    m_cr = 1'b0;
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
    chk("cr_after_rd", 8'(charreceived), 8'h00);
  endtask

  task automatic res_pulse();
    m_senderr = 1'b0; m_ovr = 1'b0;
    res_senderr = 1'b1;
    @(negedge clk);
    res_senderr = 1'b0;
    @(negedge clk);
  endtask

  // Bit-banged master transfer of nb bits; got collects miso at each sample edge.
  task automatic xfer(input logic [1:0] md, input logic lsb, input int nb,
                      input logic [7:0] tx, output logic [7:0] got);
    int idx;
    got = 8'h00;
    for (int i = 0; i < nb; i++) begin
      idx = lsb ? i : 7 - i;
      if (!md[0]) begin
        mosi = tx[idx];
        cyc(HALF);
        sck = ~md[1];
        got[idx] = miso;
        cyc(HALF);
        sck = md[1];
      end else begin
        sck = ~md[1];
        mosi = tx[idx];
        cyc(HALF);
        sck = md[1];
        got[idx] = miso;
        cyc(HALF);
      end
    end
  endtask

  // One ss-low frame of nw words (abort_bits != 0 cuts the single word short).
  task automatic frame(input logic [1:0] md, input logic lsb, input int nw, input int abort_bits,
                       input logic [23:0] mw, input logic do_mid, input logic [7:0] mid_data,
                       output logic [7:0] got0);
    logic [7:0] cur, got, w;
    int nb;
    mode = md; lsbfirst = lsb; sck = md[1];
    cyc(4);
    ss = 1'b0;
    cur = take();
    cyc(8);
    chk("miso_oe_selected", 8'(miso_oe), 8'h01);
    got0 = 8'h00;
    for (int k = 0; k < nw; k++) begin
      w  = mw[8*k +: 8];
      nb = (abort_bits != 0) ? abort_bits : 8;
      if (do_mid && k == 0) begin
        pend_wr = 1'b1; pend_data = mid_data; model_wr(mid_data);
      end
      xfer(md, lsb, nb, w, got);
      if (k == 0) got0 = got;
      if (nb == 8) begin
        chk("miso_word", got, cur);
        if (m_cr) m_ovr = 1'b1;
        m_cr = 1'b1; m_dout = w;
        cur = take();
        chk("data_out", data_out, m_dout);
        chk("charreceived", 8'(charreceived), 8'h01);
      end
    end
    cyc(6);
    ss = 1'b1;
    cyc(8);
    chk("miso_idle", 8'(miso), 8'h01);
    chk("miso_oe_idle", 8'(miso_oe), 8'h00);
    chk("buffempty_end", 8'(buffempty), 8'(!m_full));
    chk("cr_end", 8'(charreceived), 8'(m_cr));
    chk("dout_end", data_out, m_dout);
    chk("senderr_end", 8'(senderr), 8'(m_senderr));
`ifdef SPI_SLAVE_OVERRUN_EN
    chk("overrun_end", 8'(overrun), 8'(m_ovr));
`endif
  endtask

  task automatic check_reset_values();
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_buffempty", 8'(buffempty), 8'h01);
    chk("rst_charreceived", 8'(charreceived), 8'h00);
    chk("rst_senderr", 8'(senderr), 8'h00);
    chk("rst_miso", 8'(miso), 8'h01);
    chk("rst_miso_oe", 8'(miso_oe), 8'h00);
`ifdef SPI_SLAVE_OVERRUN_EN
    chk("rst_overrun", 8'(overrun), 8'h00);
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [7:0]  got0;
  logic [1:0]  r_md;
  logic        r_lsb;
  int          r_nw, r_abort;
  logic [23:0] r_mw;

  initial begin
    tbl[0] = '{md: 2'd0, lsb: 1'b0, do_wr: 1'b1, wdata: 8'hA5, mosi_w: 8'h3C, exp_miso: 8'hA5, exp_dout: 8'h3C};
    tbl[1] = '{md: 2'd3, lsb: 1'b1, do_wr: 1'b1, wdata: 8'h81, mosi_w: 8'h7E, exp_miso: 8'h81, exp_dout: 8'h7E};
    tbl[2] = '{md: 2'd1, lsb: 1'b0, do_wr: 1'b0, wdata: 8'h00, mosi_w: 8'hC3, exp_miso: 8'hFF, exp_dout: 8'hC3};
    tbl[3] = '{md: 2'd2, lsb: 1'b1, do_wr: 1'b1, wdata: 8'h5A, mosi_w: 8'h96, exp_miso: 8'h5A, exp_dout: 8'h96};

    rst = 1'b1; data_in = 8'h00; wr = 1'b0; res_senderr = 1'b0; rd = 1'b0;
    lsbfirst = 1'b0; mode = 2'd0; sck = 1'b0; ss = 1'b1; mosi = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    cyc(6);

    // Table-driven single-word frames covering the four modes and both bit orders.
    foreach (tbl[i]) begin
      if (tbl[i].do_wr) wr_pulse(tbl[i].wdata);
      frame(tbl[i].md, tbl[i].lsb, 1, 0, {16'h0000, tbl[i].mosi_w}, 1'b0, 8'h00, got0);
      chk("tbl_miso", got0, tbl[i].exp_miso);
      chk("tbl_dout", data_out, tbl[i].exp_dout);
      chk("tbl_buffempty", 8'(buffempty), 8'h01);
      rd_pulse();
    end

    // Write into a full buffer, then set/clear collision, then the held word is sent.
    wr_pulse(8'h5A);
    wr_pulse(8'h33);
    chk("senderr_set", 8'(senderr), 8'h01);
    chk("buffempty_full", 8'(buffempty), 8'h00);
    m_senderr = 1'b0; model_wr(8'h44);
    wr = 1'b1; res_senderr = 1'b1; data_in = 8'h44;
    @(negedge clk);
    wr = 1'b0; res_senderr = 1'b0;
    @(negedge clk);
    chk("senderr_set_wins", 8'(senderr), 8'h01);
    res_pulse();
    chk("senderr_cleared", 8'(senderr), 8'h00);
    frame(2'd0, 1'b0, 1, 0, 24'h000055, 1'b0, 8'h00, got0);
    chk("held_word_sent", got0, 8'h5A);
    rd_pulse();

    // Back-to-back words with a refill during word 1: 0x22, 0x11, 0xFF.
    wr_pulse(8'h22);
    frame(2'd0, 1'b0, 3, 0, 24'h563412, 1'b1, 8'h11, got0);
    chk("b2b_first", got0, 8'h22);
    chk("b2b_last_dout", data_out, 8'h56);
    rd_pulse();
    res_pulse();

    // ss rises after 4 bits: no word, next frame still aligned.
    wr_pulse(8'hC6);
    frame(2'd0, 1'b0, 1, 4, 24'h0000F0, 1'b0, 8'h00, got0);
    chk("abort_no_cr", 8'(charreceived), 8'h00);
    frame(2'd0, 1'b0, 1, 0, 24'h0000E7, 1'b0, 8'h00, got0);
    chk("after_abort_dout", data_out, 8'hE7);
    chk("after_abort_miso", got0, 8'hFF);
    rd_pulse();

    // Reset mid-transfer: slave stays deselected until ss is seen high.
    wr_pulse(8'h77);
    mode = 2'd0; lsbfirst = 1'b0; sck = 1'b0;
    cyc(4);
    ss = 1'b0;
    cyc(8);
    xfer(2'd0, 1'b0, 3, 8'hF0, got0);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_values();
    xfer(2'd0, 1'b0, 8, 8'hAA, got0);
    chk("sync_ignores_cr", 8'(charreceived), 8'h00);
    chk("sync_ignores_oe", 8'(miso_oe), 8'h00);
    chk("sync_ignores_miso", 8'(miso), 8'h01);
    sck = 1'b0; ss = 1'b1;
    cyc(10);
    wr_pulse(8'h3C);
    frame(2'd0, 1'b0, 1, 0, 24'h000099, 1'b0, 8'h00, got0);
    chk("post_rst_miso", got0, 8'h3C);
    chk("post_rst_dout", data_out, 8'h99);
    rd_pulse();

`ifdef SPI_SLAVE_OVERRUN_EN
    // Two words without rd set overrun and keep the newest word.
    frame(2'd1, 1'b0, 2, 0, 24'h00B2A1, 1'b0, 8'h00, got0);
    chk("overrun_set", 8'(overrun), 8'h01);
    chk("overrun_dout", data_out, 8'hB2);
    res_pulse();
    chk("overrun_cleared", 8'(overrun), 8'h00);
    rd_pulse();
`endif

    // Randomized frames against the model.
    for (int r = 0; r < 16; r++) begin
      r_md    = 2'($urandom_range(0, 3));
      r_lsb   = 1'($urandom_range(0, 1));
      r_nw    = $urandom_range(1, 2);
      r_abort = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
      if (r_abort != 0) r_nw = 1;
      r_mw    = 24'($urandom);
      if ($urandom_range(0, 1) == 1) wr_pulse(8'($urandom));
      frame(r_md, r_lsb, r_nw, r_abort, r_mw, 1'($urandom_range(0, 1)), 8'($urandom), got0);
      if ($urandom_range(0, 1) == 1) rd_pulse();
      if ($urandom_range(0, 3) == 0) res_pulse();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
